// File: rtl/dwc_recovery.sv
// Duplication-with-comparison checker: forwards matching pairs, requests
// upstream retries on mismatch and latches a fatal state once the budget is spent.
module dwc_recovery #(
   parameter int WIDTH     = 1,
   parameter int MAX_RETRY = 3,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             port_in_valid,
   input  logic [WIDTH-1:0] port_in_0,
   input  logic [WIDTH-1:0] port_in_1,
   output logic             port_in_ready,
   output logic             port_out_valid,
   output logic [WIDTH-1:0] port_out,
   output logic             port_retry,
   output logic             port_error,
   output logic             port_fatal,
   output logic [CNT_W-1:0] port_err_count
);

   // A zero budget still needs a 1-bit counter to stay a legal declaration.
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0]    MAX_R   = RW'(MAX_RETRY);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {NORMAL, RETRY, FATAL} state_e;

   state_e           state_q, state_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             outv_q, outv_d;
   logic             rtry_q, rtry_d;
   logic             err_q, err_d;
   logic             fatal_q, fatal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept, match;

   assign port_in_ready = (state_q != FATAL);
   assign accept        = port_in_valid && port_in_ready;
   assign match         = (port_in_0 == port_in_1);

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      out_d   = out_q;
      outv_d  = 1'b0;
      rtry_d  = 1'b0;
      err_d   = 1'b0;
      fatal_d = fatal_q;
      cnt_d   = cnt_q;
      if (accept) begin
         if (match) begin
            out_d   = port_in_0;
            outv_d  = 1'b1;
            retry_d = '0;
            state_d = NORMAL;
         end else begin
            err_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if ((state_q == NORMAL && MAX_RETRY == 0) ||
                (state_q == RETRY && retry_q >= MAX_R)) begin
               state_d = FATAL;
               fatal_d = 1'b1;
            end else begin
               retry_d = (state_q == NORMAL) ? RW'(1) : retry_q + RW'(1);
               rtry_d  = 1'b1;
               state_d = RETRY;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= NORMAL;
         retry_q <= '0;
         out_q   <= '0;
         outv_q  <= 1'b0;
         rtry_q  <= 1'b0;
         err_q   <= 1'b0;
         fatal_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         out_q   <= out_d;
         outv_q  <= outv_d;
         rtry_q  <= rtry_d;
         err_q   <= err_d;
         fatal_q <= fatal_d;
         cnt_q   <= cnt_d;
      end
   end

   assign port_out_valid = outv_q;
   assign port_out       = out_q;
   assign port_retry     = rtry_q;
   assign port_error     = err_q;
   assign port_fatal     = fatal_q;
   assign port_err_count = cnt_q;

endmodule

// File: tb/tb_dwc_recovery.sv
// Drives three parameterisations of dwc_recovery with one stimulus stream and
// checks each against a consecutive-mismatch reference model via a scoreboard.
module tb_dwc_recovery;

   typedef struct packed {
      logic       ready;
      logic       outv;
      logic [3:0] out;
      logic       retry;
      logic       error;
      logic       fatal;
      logic [7:0] cnt;
   } exp_t;

   typedef struct packed {
      exp_t [2:0] d;
   } trio_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld = 1'b0;
   logic [3:0] a = '0, b = '0;

   logic       rdy [3];
   logic       ov [3];
   logic [3:0] po [3];
   logic       rt [3];
   logic       er [3];
   logic       ft [3];
   logic [7:0] ec0, ec2;
   logic [1:0] ec1;

   always #5 clk = ~clk;

   dwc_recovery #(.WIDTH(4), .MAX_RETRY(3), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .port_in_valid(vld), .port_in_0(a), .port_in_1(b),
      .port_in_ready(rdy[0]), .port_out_valid(ov[0]), .port_out(po[0]),
      .port_retry(rt[0]), .port_error(er[0]), .port_fatal(ft[0]), .port_err_count(ec0));
   dwc_recovery #(.WIDTH(4), .MAX_RETRY(7), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .port_in_valid(vld), .port_in_0(a), .port_in_1(b),
      .port_in_ready(rdy[1]), .port_out_valid(ov[1]), .port_out(po[1]),
      .port_retry(rt[1]), .port_error(er[1]), .port_fatal(ft[1]), .port_err_count(ec1));
   dwc_recovery #(.WIDTH(4), .MAX_RETRY(0), .CNT_W(8)) u2 (
      .clk(clk), .rst(rst), .port_in_valid(vld), .port_in_0(a), .port_in_1(b),
      .port_in_ready(rdy[2]), .port_out_valid(ov[2]), .port_out(po[2]),
      .port_retry(rt[2]), .port_error(er[2]), .port_fatal(ft[2]), .port_err_count(ec2));

   // Reference model: fatal once consecutive mismatches exceed the budget.
   int         budget [3] = '{3, 7, 0};
   int         cmax   [3] = '{255, 3, 255};
   bit         m_fatal [3];
   int         m_mis [3];
   int         m_err [3];
   logic [3:0] m_good [3];

   trio_t q[$];
   int    n_chk = 0, n_pass = 0;
   bit    done = 1'b0;

   function automatic exp_t model_step(int d, bit r, bit v, logic [3:0] x, logic [3:0] y);
      exp_t e;
      e = '0;
      if (r) begin
         m_fatal[d] = 1'b0; m_mis[d] = 0; m_err[d] = 0; m_good[d] = '0;
      end else if (v && !m_fatal[d]) begin
         if (x == y) begin
            m_good[d] = x; m_mis[d] = 0; e.outv = 1'b1;
         end else begin
            e.error = 1'b1;
            if (m_err[d] < cmax[d]) m_err[d]++;
            m_mis[d]++;
            if (m_mis[d] > budget[d]) m_fatal[d] = 1'b1;
            else e.retry = 1'b1;
         end
      end
      e.ready = !m_fatal[d];
      e.out   = m_good[d];
      e.fatal = m_fatal[d];
      e.cnt   = 8'(m_err[d]);
      return e;
   endfunction

   task automatic cyc(bit r, bit v, logic [3:0] x, logic [3:0] y);
      trio_t t;
      @(negedge clk);
      rst = r; vld = v; a = x; b = y;
      for (int d = 0; d < 3; d++) t.d[d] = model_step(d, r, v, x, y);
      q.push_back(t);
   endtask

   // Monitor: every cycle the DUTs present a response, compare it with the oldest expectation.
   initial begin
      trio_t t;
      exp_t  act;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            t = q.pop_front();
            for (int d = 0; d < 3; d++) begin
               act.ready = rdy[d]; act.outv = ov[d]; act.out = po[d];
               act.retry = rt[d]; act.error = er[d]; act.fatal = ft[d];
               act.cnt   = (d == 0) ? ec0 : (d == 1) ? {6'b0, ec1} : ec2;
               n_chk++;
               if (act === t.d[d] && !(act.outv && (act.error || act.retry))) n_pass++;
               else $display("FAIL dut%0d outputs at %0t: got rdy=%b ov=%b out=%h rt=%b er=%b ft=%b cnt=%0d, want rdy=%b ov=%b out=%h rt=%b er=%b ft=%b cnt=%0d",
                             d, $time, act.ready, act.outv, act.out, act.retry, act.error, act.fatal, act.cnt,
                             t.d[d].ready, t.d[d].outv, t.d[d].out, t.d[d].retry, t.d[d].error, t.d[d].fatal, t.d[d].cnt);
            end
         end
      end
   end

   initial begin
      cyc(1, 0, 0, 0);
      cyc(1, 1, 4'h7, 4'h7);            // reset wins over a simultaneous transfer
      cyc(0, 1, 4'hA, 4'hA);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 4'h5, 4'h4);
      cyc(0, 1, 4'h5, 4'h5);
      for (int i = 0; i < 4; i++) cyc(0, 1, 4'(i), 4'(i + 1));
      cyc(0, 1, 4'h9, 4'h9);
      cyc(0, 1, 4'h2, 4'h3);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 4'h3, 4'h3);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 4'hC, 4'(i));
         repeat (i + 1) cyc(0, 0, 4'hF, 4'h0);
      end
      cyc(0, 1, 4'h1, 4'h1);
      cyc(1, 1, 4'h6, 4'h1);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 4'h8, 4'h0);
         cyc(0, 1, 4'(i), 4'(i));
      end
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         logic [3:0] x, y;
         x = 4'($urandom);
         y = ($urandom_range(0, 2) == 0) ? 4'($urandom) : x;
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, x, y);
      end
      cyc(0, 0, 0, 0);
      repeat (20) begin
         if (q.size() != 0) @(negedge clk);
      end
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL scoreboard drain: %0d left, want 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
